// File: rtl/cla_wide_add_seq_pkg.sv
// Shared constants and FSM encoding for the nibble-serial CLA adder.
package cla_wide_add_seq_pkg;

  // Width of the single CLA slice that is time-multiplexed over the operands.
  localparam int NIBBLE = 4;

  // 2'd3 is unreachable; the next-state logic sends it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_wide_add_seq_cla_adder.sv
// 4-bit carry-lookahead slice: all internal carries from generate/propagate.
module cla_adder
  import cla_wide_add_seq_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              c0,
  output logic [NIBBLE-1:0] s,
  output logic              c4
);

  logic [3:0] g, p;
  logic [4:0] c;

  // Flat two-level carry equations, no ripple inside the slice.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c[3:0];
    c4   = c[4];
  end

endmodule

// File: rtl/cla_wide_add_seq.sv
// WIDTH-bit add/subtract built from one 4-bit CLA slice stepped LSB nibble
// first, with valid/ready handshakes on request and result sides.
module cla_wide_add_seq
  import cla_wide_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBBLE;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int BW   = $clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              carry;
  logic [BW-1:0]     base;
  logic [NIBBLE-1:0] a_nib, b_nib, s_nib;
  logic              c4;
  logic              accept;

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign accept      = start_valid & start_ready;

  // Bit offset of the current nibble (idx * 4), sized to index the operands.
  assign base  = BW'({idx, 2'b00});
  assign a_nib = a_r[base +: NIBBLE];
  assign b_nib = b_r[base +: NIBBLE];

  cla_adder u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .c0 (carry),
    .s  (s_nib),
    .c4 (c4)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, leave RUN on the last nibble, drain on res_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)            state_nxt = ST_RUN;
      ST_RUN:  if (idx == IDX_LAST)   state_nxt = ST_DONE;
      ST_DONE: if (res_ready)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_r   <= op_a;
            // Subtract as A + ~B + 1; cin is irrelevant then.
            b_r   <= sub ? ~op_b : op_b;
            carry <= sub | cin;
            idx   <= '0;
            sum   <= '0;
          end
        end
        ST_RUN: begin
          sum[base +: NIBBLE] <= s_nib;
          carry               <= c4;
          if (idx == IDX_LAST) begin
            cout <= c4;
            // Same-sign operands producing a different-sign result.
            ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s_nib[NIBBLE-1] != a_r[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
